rotation_sequencer: RTL and testbench

- Owns the playfield rotation angle. Produces the 10-bit rotation_offset (1024 units per turn) consumed by the sextant mapper and the wall renderer.
- Advances the angle once per video frame at a programmable speed. Performs decelerate/reverse/accelerate direction flips, either on request or on a periodic auto-flip timer.
- Never lands on an angle that puts any of the mapper's three boundary slopes on a tangent singularity.
- Sits between game-state logic and the per-pixel mapping datapath.

---
 rtl/rotation_sequencer_if.sv | 24 ++
 rtl/rotation_sequencer.sv | 145 ++++++++++++++
 tb/tb_rotation_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotation_sequencer_if.sv
// Control and angle-output bundle between game-state logic and the rotation sequencer.
// master = game-state side driving controls, slave = sequencer producing the angle.
interface rotation_sequencer_if;
  logic       frame_start;
  logic       run;
  logic [3:0] speed_in;
  logic       speed_load;
  logic       flip_req;
  logic [9:0] rotation_offset;
  logic       direction;
  logic [3:0] cur_speed;
  logic       flipping;
  logic       update_strobe;

  modport master (
    output frame_start, run, speed_in, speed_load, flip_req,
    input  rotation_offset, direction, cur_speed, flipping, update_strobe
  );

  modport slave (
    input  frame_start, run, speed_in, speed_load, flip_req,
    output rotation_offset, direction, cur_speed, flipping, update_strobe
  );
endinterface

// File: rtl/rotation_sequencer.sv
// Playfield rotation angle: per-frame stepping with decel/reverse/accel flips; result visible
// one cycle after frame_start. No backpressure: frame_start and control pulses are always accepted.
module rotation_sequencer #(
  parameter int SPEED_DEFAULT = 4,
  parameter int MAX_SPEED     = 15,
  parameter int FLIP_PERIOD   = 180
) (
  input logic                 Clk,
  input logic                 Reset_n,
  rotation_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SPIN       = 2'd1,
    FLIP_DECEL = 2'd2,
    FLIP_ACCEL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  offset_q, offset_d;
  logic        dir_q, dir_d;
  logic [3:0]  spd_q, spd_d;
  logic [3:0]  tgt_q, tgt_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        strobe_q, strobe_d;

  logic [3:0]  load_val;
  logic [3:0]  step_spd;
  logic        do_step;

  // Offsets where one of the mapper's boundary slopes hits a tangent singularity.
  function automatic logic is_forbidden(input logic [9:0] v);
    case (v)
      10'd85, 10'd256, 10'd427, 10'd597, 10'd768, 10'd939: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Forbidden values are far apart, so a single nudge in the travel direction always clears them.
  function automatic logic [9:0] step_offset(input logic [9:0] cur, input logic [3:0] spd,
                                             input logic dir);
    logic [9:0] raw;
    raw = dir ? (cur - {6'd0, spd}) : (cur + {6'd0, spd});
    if (is_forbidden(raw)) raw = dir ? (raw - 10'd1) : (raw + 10'd1);
    return raw;
  endfunction

  assign load_val = (bus.speed_in > 4'(MAX_SPEED)) ? 4'(MAX_SPEED) : bus.speed_in;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    dir_d    = dir_q;
    spd_d    = spd_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    strobe_d = 1'b0;
    step_spd = spd_q;
    do_step  = 1'b0;

    if (bus.speed_load) begin
      tgt_d = load_val;
      if (state_q == IDLE || state_q == SPIN) spd_d = load_val;
    end

    if (bus.flip_req && state_q == SPIN) pend_d = 1'b1;

    if (bus.frame_start) begin
      if (!bus.run) begin
        state_d = IDLE;
        spd_d   = tgt_d;
        cnt_d   = 16'd0;
        pend_d  = 1'b0;
      end else begin
        case (state_q)
          IDLE: state_d = SPIN;
          SPIN: begin
            do_step = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            if (bus.flip_req || pend_q ||
                (FLIP_PERIOD != 0 && cnt_q == 16'(FLIP_PERIOD - 1))) begin
              state_d = FLIP_DECEL;
              cnt_d   = 16'd0;
              pend_d  = 1'b0;
            end
          end
          FLIP_DECEL: begin
            if (spd_q == 4'd0) begin
              dir_d   = ~dir_q;
              state_d = FLIP_ACCEL;
            end else begin
              do_step = 1'b1;
              spd_d   = spd_q - 4'd1;
            end
          end
          FLIP_ACCEL: begin
            // A target lowered mid-flip below the ramp snaps the speed straight down.
            step_spd = (spd_q >= tgt_q) ? tgt_q : (spd_q + 4'd1);
            do_step  = 1'b1;
            spd_d    = step_spd;
            if (step_spd >= tgt_q) state_d = SPIN;
          end
          default: state_d = IDLE;
        endcase
      end

      if (do_step) begin
        offset_d = step_offset(offset_q, step_spd, dir_q);
        strobe_d = (offset_d != offset_q);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      offset_q <= 10'd0;
      dir_q    <= 1'b0;
      spd_q    <= 4'(SPEED_DEFAULT);
      tgt_q    <= 4'(SPEED_DEFAULT);
      cnt_q    <= 16'd0;
      pend_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      dir_q    <= dir_d;
      spd_q    <= spd_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.rotation_offset = offset_q;
  assign bus.direction       = dir_q;
  assign bus.cur_speed       = spd_q;
  assign bus.flipping        = (state_q == FLIP_DECEL) || (state_q == FLIP_ACCEL);
  assign bus.update_strobe   = strobe_q;

endmodule

// File: tb/tb_rotation_sequencer.sv
// Directed bench: default-period instance for stepping/flip/run tests, FLIP_PERIOD=4 instance for auto flip.
module tb_rotation_sequencer;
  logic Clk;
  logic Reset_n;
  int   tests;
  int   fails;

  rotation_sequencer_if bus();
  rotation_sequencer_if bus_af();

  rotation_sequencer dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  rotation_sequencer #(.FLIP_PERIOD(4)) dut_af (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus_af.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    bus.frame_start = 0; bus.run = 0; bus.speed_in = 0; bus.speed_load = 0; bus.flip_req = 0;
    bus_af.frame_start = 0; bus_af.run = 0; bus_af.speed_in = 0; bus_af.speed_load = 0;
    bus_af.flip_req = 0;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  // Returns at the falling edge just after the frame_start edge, when the new angle is visible.
  task automatic frame(input bit af);
    @(negedge Clk);
    if (af) bus_af.frame_start = 1'b1; else bus.frame_start = 1'b1;
    @(negedge Clk);
    bus.frame_start = 1'b0;
    bus_af.frame_start = 1'b0;
  endtask

  task automatic set_speed(input bit af, input logic [3:0] v);
    @(negedge Clk);
    if (af) begin bus_af.speed_in = v; bus_af.speed_load = 1'b1; end
    else begin bus.speed_in = v; bus.speed_load = 1'b1; end
    @(negedge Clk);
    bus.speed_load = 1'b0;
    bus_af.speed_load = 1'b0;
  endtask

  task automatic pulse_flip(input bit af);
    @(negedge Clk);
    if (af) bus_af.flip_req = 1'b1; else bus.flip_req = 1'b1;
    @(negedge Clk);
    bus.flip_req = 1'b0;
    bus_af.flip_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.rotation_offset !== 10'd0 || bus.direction !== 1'b0 || bus.cur_speed !== 4'd4 ||
        bus.flipping !== 1'b0 || bus.update_strobe !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: off=%0d dir=%0b spd=%0d flip=%0b stb=%0b, need 0 0 4 0 0",
               bus.rotation_offset, bus.direction, bus.cur_speed, bus.flipping, bus.update_strobe);
    end
  endtask

  task automatic test_basic_step();
    do_reset();
    bus.run = 1'b1;
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd0 || bus.update_strobe !== 1'b0) begin
      fails++;
      $display("FAIL enter_spin: off=%0d stb=%0b, need 0 0", bus.rotation_offset, bus.update_strobe);
    end
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd4 || bus.update_strobe !== 1'b1) begin
      fails++;
      $display("FAIL step1: off=%0d stb=%0b, need 4 1", bus.rotation_offset, bus.update_strobe);
    end
    @(negedge Clk);
    tests++;
    if (bus.update_strobe !== 1'b0) begin
      fails++;
      $display("FAIL strobe_width: stb=%0b, need 0", bus.update_strobe);
    end
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd8 || bus.update_strobe !== 1'b1) begin
      fails++;
      $display("FAIL step2: off=%0d stb=%0b, need 8 1", bus.rotation_offset, bus.update_strobe);
    end
  endtask

  task automatic test_forbidden();
    do_reset();
    bus.run = 1'b1;
    frame(0);
    for (int i = 1; i <= 20; i++) begin
      frame(0);
      tests++;
      if (bus.rotation_offset !== 10'(4 * i)) begin
        fails++;
        $display("FAIL ramp_to_80 frame %0d: off=%0d, need %0d", i, bus.rotation_offset, 4 * i);
      end
    end
    set_speed(0, 4'd5);
    tests++;
    if (bus.cur_speed !== 4'd5) begin
      fails++;
      $display("FAIL load_spin: spd=%0d, need 5", bus.cur_speed);
    end
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd86 || bus.update_strobe !== 1'b1) begin
      fails++;
      $display("FAIL skip_85: off=%0d stb=%0b, need 86 1", bus.rotation_offset, bus.update_strobe);
    end
    repeat (33) frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd251) begin
      fails++;
      $display("FAIL reach_251: off=%0d, need 251", bus.rotation_offset);
    end
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd257) begin
      fails++;
      $display("FAIL skip_256_up: off=%0d, need 257", bus.rotation_offset);
    end
    frame(0);
    pulse_flip(0);
    repeat (12) frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd267 || bus.direction !== 1'b1 || bus.flipping !== 1'b0) begin
      fails++;
      $display("FAIL flip_at_262: off=%0d dir=%0b flip=%0b, need 267 1 0",
               bus.rotation_offset, bus.direction, bus.flipping);
    end
    frame(0);
    set_speed(0, 4'd1);
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd261) begin
      fails++;
      $display("FAIL reach_261: off=%0d, need 261", bus.rotation_offset);
    end
    set_speed(0, 4'd5);
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd255) begin
      fails++;
      $display("FAIL skip_256_down: off=%0d, need 255", bus.rotation_offset);
    end
  endtask

  task automatic test_flip();
    int exp_off[9]  = '{9, 12, 14, 15, 15, 14, 12, 9, 6};
    int exp_spd[9]  = '{3, 2, 1, 0, 0, 1, 2, 3, 3};
    int exp_dir[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    int exp_flp[9]  = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    int exp_stb[9]  = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    do_reset();
    set_speed(0, 4'd3);
    bus.run = 1'b1;
    frame(0);
    frame(0);
    frame(0);
    pulse_flip(0);
    tests++;
    if (bus.flipping !== 1'b0 || bus.rotation_offset !== 10'd6) begin
      fails++;
      $display("FAIL flip_pending: flip=%0b off=%0d, need 0 6", bus.flipping, bus.rotation_offset);
    end
    for (int i = 0; i < 9; i++) begin
      frame(0);
      tests++;
      if (bus.rotation_offset !== 10'(exp_off[i]) || bus.cur_speed !== 4'(exp_spd[i]) ||
          bus.direction !== 1'(exp_dir[i]) || bus.flipping !== 1'(exp_flp[i]) ||
          bus.update_strobe !== 1'(exp_stb[i])) begin
        fails++;
        $display("FAIL flip_seq frame %0d: off=%0d spd=%0d dir=%0b flip=%0b stb=%0b, need %0d %0d %0d %0d %0d",
                 i, bus.rotation_offset, bus.cur_speed, bus.direction, bus.flipping,
                 bus.update_strobe, exp_off[i], exp_spd[i], exp_dir[i], exp_flp[i], exp_stb[i]);
      end
    end
  endtask

  task automatic test_autoflip();
    int exp_off[13] = '{2, 4, 6, 8, 10, 11, 11, 10, 8, 6, 4, 2, 0};
    int exp_dir[13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int exp_flp[13] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    do_reset();
    set_speed(1, 4'd2);
    bus_af.run = 1'b1;
    frame(1);
    for (int i = 0; i < 13; i++) begin
      frame(1);
      tests++;
      if (bus_af.rotation_offset !== 10'(exp_off[i]) || bus_af.direction !== 1'(exp_dir[i]) ||
          bus_af.flipping !== 1'(exp_flp[i])) begin
        fails++;
        $display("FAIL autoflip frame %0d: off=%0d dir=%0b flip=%0b, need %0d %0d %0d",
                 i, bus_af.rotation_offset, bus_af.direction, bus_af.flipping,
                 exp_off[i], exp_dir[i], exp_flp[i]);
      end
      if (i == 4 || i == 7) pulse_flip(1);
    end
  endtask

  task automatic test_run_stop();
    do_reset();
    set_speed(0, 4'd3);
    bus.run = 1'b1;
    frame(0);
    frame(0);
    pulse_flip(0);
    repeat (3) frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd11 || bus.cur_speed !== 4'd1 || bus.flipping !== 1'b1) begin
      fails++;
      $display("FAIL decel_to_1: off=%0d spd=%0d flip=%0b, need 11 1 1",
               bus.rotation_offset, bus.cur_speed, bus.flipping);
    end
    bus.run = 1'b0;
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd11 || bus.cur_speed !== 4'd3 || bus.flipping !== 1'b0 ||
        bus.direction !== 1'b0 || bus.update_strobe !== 1'b0) begin
      fails++;
      $display("FAIL stop_idle: off=%0d spd=%0d flip=%0b dir=%0b stb=%0b, need 11 3 0 0 0",
               bus.rotation_offset, bus.cur_speed, bus.flipping, bus.direction, bus.update_strobe);
    end
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd11 || bus.update_strobe !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: off=%0d stb=%0b, need 11 0", bus.rotation_offset, bus.update_strobe);
    end
    bus.run = 1'b1;
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd11 || bus.update_strobe !== 1'b0) begin
      fails++;
      $display("FAIL resume_enter: off=%0d stb=%0b, need 11 0", bus.rotation_offset, bus.update_strobe);
    end
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd14 || bus.direction !== 1'b0) begin
      fails++;
      $display("FAIL resume_step: off=%0d dir=%0b, need 14 0", bus.rotation_offset, bus.direction);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    set_speed(0, 4'd15);
    bus.run = 1'b1;
    frame(0);
    repeat (68) frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd1020) begin
      fails++;
      $display("FAIL reach_1020: off=%0d, need 1020", bus.rotation_offset);
    end
    set_speed(0, 4'd2);
    frame(0);
    set_speed(0, 4'd4);
    pulse_flip(0);
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd2 || bus.update_strobe !== 1'b1) begin
      fails++;
      $display("FAIL wrap_up: off=%0d stb=%0b, need 2 1", bus.rotation_offset, bus.update_strobe);
    end
    repeat (9) frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd2 || bus.direction !== 1'b1 || bus.flipping !== 1'b0) begin
      fails++;
      $display("FAIL flip_back_to_2: off=%0d dir=%0b flip=%0b, need 2 1 0",
               bus.rotation_offset, bus.direction, bus.flipping);
    end
    frame(0);
    tests++;
    if (bus.rotation_offset !== 10'd1022 || bus.update_strobe !== 1'b1) begin
      fails++;
      $display("FAIL wrap_down: off=%0d stb=%0b, need 1022 1", bus.rotation_offset, bus.update_strobe);
    end
    Reset_n = 1'b0;
    #1;
    tests++;
    if (bus.rotation_offset !== 10'd0 || bus.direction !== 1'b0 || bus.cur_speed !== 4'd4 ||
        bus.flipping !== 1'b0 || bus.update_strobe !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: off=%0d dir=%0b spd=%0d flip=%0b stb=%0b, need 0 0 4 0 0",
               bus.rotation_offset, bus.direction, bus.cur_speed, bus.flipping, bus.update_strobe);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset_n = 1'b0;
    test_reset();
    test_basic_step();
    test_forbidden();
    test_flip();
    test_autoflip();
    test_run_stop();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
